da_fir_core: RTL

- Bit-serial distributed-arithmetic FIR engine; the reader side of the offset-binary-coded coefficient ROM.
- Holds a delay line of the last `taps` samples and issues one ROM address per sample bit, LSB first.
- Sign-corrects each returned ROM word and shift-accumulates it into an exact filter output.
- Sits between the sample source and the downstream datapath; the ROM instance sits beside it, driven by `rom_address`/`rom_en`.

---
 rtl/da_fir_core.sv | 128 ++++++++++++
 1 files changed

// File: rtl/da_fir_core.sv
// Bit-serial distributed-arithmetic FIR: drives one ROM address per sample bit (LSB first),
// sign-corrects the offset-binary ROM word and shift-accumulates it into y[n] = sum A_k*x[n-k].
module da_fir_core #(
  parameter int data_width = 16,
  parameter int taps       = 3,
  parameter int word_width = 16,
  parameter logic signed [word_width+data_width:0] offset = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [data_width-1:0]            in_data,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic [taps-1:0]                  rom_address,
  output logic                             rom_en,
  input  logic [word_width-1:0]            rom_data,
  output logic [word_width+data_width-1:0] out_data,
  output logic                             out_valid,
  input  logic                             out_ready
);

  localparam int AW = word_width + data_width + 1;
  localparam int CW = (data_width > 1) ? $clog2(data_width) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(data_width - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [data_width-1:0]  tap_q [taps];
  logic [data_width-1:0]  tap_d [taps];
  logic signed [AW-1:0]   acc_q, acc_d;
  logic [CW-1:0]          bit_q, bit_d;

  logic [taps-1:0]        addr_w;
  logic signed [AW-1:0]   rom_ext;
  logic signed [AW-1:0]   r_corr;
  logic signed [AW-1:0]   term;

  // Column of sample bits at the current bit position, one per tap.
  always_comb begin
    addr_w = '0;
    for (int k = 0; k < taps; k++) begin
      addr_w[k] = tap_q[k][bit_q];
    end
  end

  // The ROM only stores half the table; when address[0] is set it returns the
  // entry for the complemented address, which is the negated value we need.
  assign rom_ext = {{(AW-word_width){rom_data[word_width-1]}}, rom_data};
  assign r_corr  = addr_w[0] ? -rom_ext : rom_ext;
  assign term    = r_corr <<< bit_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    bit_d       = bit_q;
    for (int k = 0; k < taps; k++) begin
      tap_d[k] = tap_q[k];
    end
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    rom_en      = 1'b0;
    rom_address = '0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          tap_d[0] = in_data;
          for (int k = 1; k < taps; k++) begin
            tap_d[k] = tap_q[k-1];
          end
          acc_d   = offset;
          bit_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        rom_en      = 1'b1;
        rom_address = addr_w;
        // The sample MSB carries negative weight in two's complement.
        if (bit_q == LAST_BIT) begin
          acc_d   = acc_q - term;
          bit_d   = '0;
          state_d = DONE;
        end else begin
          acc_d = acc_q + term;
          bit_d = bit_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      bit_q   <= '0;
      for (int k = 0; k < taps; k++) begin
        tap_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      bit_q   <= bit_d;
      for (int k = 0; k < taps; k++) begin
        tap_q[k] <= tap_d[k];
      end
    end
  end

  // The accumulator holds 2*y; the halving is exact for a well-formed ROM.
  assign out_data = acc_q[AW-1:1];

endmodule
